// File: rtl/imm_ext_fifo.sv
// LEGv8 immediate extractor/extender feeding a DEPTH-entry circular output buffer.
// Optional IMM_EXT_MOVW_EN: fmt 4 (IW) applies the 16*hw shift from instr[22:21].
module imm_ext_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [2:0]                 fmt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          imm_out,
  output logic                       imm_err,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [7:0]                 err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [63:0]       ext64;
  logic              illegal;
  logic [DATA_W-1:0] imm_ext;
  logic              push;
  logic              pop;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [DATA_W-1:0] mem     [DEPTH];
  logic              err_mem [DEPTH];
  logic              unused_instr;

  // Sign rule is applied on the raw field before the word shift.
  always_comb begin
    ext64   = '0;
    illegal = 1'b0;
    case (fmt)
      3'd0: ext64 = {52'd0, instr[21:10]};
      3'd1: ext64 = {{55{instr[20]}}, instr[20:12]};
      3'd2: ext64 = {{36{instr[25]}}, instr[25:0], 2'b00};
      3'd3: ext64 = {{43{instr[23]}}, instr[23:5], 2'b00};
`ifdef IMM_EXT_MOVW_EN
      3'd4: ext64 = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};
`else
      3'd4: ext64 = {48'd0, instr[20:5]};
`endif
      3'd5: ext64 = {55'd0, instr[20:12]};
      default: illegal = 1'b1;
    endcase
  end

  assign imm_ext      = ext64[DATA_W-1:0];
  assign unused_instr = ^instr;

  // Full blocks pushes regardless of a same-cycle pop, keeping out_ready off in_ready.
  assign in_ready  = (occupancy != OW'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign imm_out   = mem[rptr];
  assign imm_err   = err_mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
      err_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]     <= '0;
        err_mem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem[wptr]     <= imm_ext;
        err_mem[wptr] <= illegal;
        wptr          <= wptr + 1'b1;
        if (illegal && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_fifo.sv
// Directed self-checking bench for imm_ext_fifo at DATA_W=64, DEPTH=2.
module tb_imm_ext_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [2:0]  fmt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] imm_out;
  logic        imm_err;
  logic [1:0]  occupancy;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;

  imm_ext_fifo #(.DATA_W(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .fmt(fmt), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .imm_err(imm_err), .occupancy(occupancy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic push_one(input logic [31:0] i, input logic [2:0] f);
    instr = i; fmt = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL rst_occ got %0d want 0", occupancy); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
    tests++; if (imm_out !== 64'd0 || imm_err !== 1'b0) begin fails++; $display("FAIL rst_head got %h/%0b want 0/0", imm_out, imm_err); end
  endtask

  task automatic test_extract(input string name, input logic [31:0] i, input logic [2:0] f,
                              input logic [63:0] exp);
    push_one(i, f);
    tests++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin fails++; $display("FAIL %s_valid got v=%0b occ=%0d want v=1 occ=1", name, out_valid, occupancy); end
    tests++; if (imm_out !== exp || imm_err !== 1'b0) begin fails++; $display("FAIL %s_value got %h err=%0b want %h err=0", name, imm_out, imm_err, exp); end
    pop_one();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_drain got out_valid=%0b want 0", name, out_valid); end
  endtask

  task automatic test_formats();
    test_extract("ialu", 32'h003F_FC00, 3'd0, 64'h0000_0000_0000_0FFF);
    test_extract("dt_sign", 32'h001C_7000, 3'd1, 64'hFFFF_FFFF_FFFF_FFC7);
    test_extract("dtu_zero", 32'h001C_7000, 3'd5, 64'h0000_0000_0000_01C7);
    test_extract("b_shift", 32'h03FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC);
    test_extract("cb_shift", 32'h0000_0020, 3'd3, 64'h0000_0000_0000_0004);
`ifdef IMM_EXT_MOVW_EN
    test_extract("movw", 32'h0055_79A0, 3'd4, 64'h0000_ABCD_0000_0000);
`else
    test_extract("movw", 32'h0055_79A0, 3'd4, 64'h0000_0000_0000_ABCD);
`endif
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_one(32'd1 << 10, 3'd0);
    tests++; if (imm_out !== 64'd1) begin fails++; $display("FAIL bp_head_a got %h want 1", imm_out); end
    instr = 32'd2 << 10; fmt = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got occ=%0d rdy=%0b want 2/0", occupancy, in_ready); end
    instr = 32'd3 << 10;
    @(posedge clk); #1;
    tests++; if (occupancy !== 2'd2 || imm_out !== 64'd1) begin fails++; $display("FAIL bp_hold got occ=%0d head=%h want 2/1", occupancy, imm_out); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || imm_out !== 64'd2) begin fails++; $display("FAIL bp_pop1 got occ=%0d rdy=%0b head=%h want 1/1/2", occupancy, in_ready, imm_out); end
    @(posedge clk); #1;
    tests++; if (occupancy !== 2'd1 || imm_out !== 64'd3) begin fails++; $display("FAIL bp_pushpop got occ=%0d head=%h want 1/3", occupancy, imm_out); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got occ=%0d v=%0b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_illegal();
    push_one(32'hFFFF_FFFF, 3'd6);
    tests++; if (imm_out !== 64'd0 || imm_err !== 1'b1 || err_cnt !== 8'd1) begin fails++; $display("FAIL ill_fmt6 got %h err=%0b cnt=%0d want 0/1/1", imm_out, imm_err, err_cnt); end
    pop_one();
    push_one(32'hFFFF_FFFF, 3'd7);
    tests++; if (imm_out !== 64'd0 || imm_err !== 1'b1 || err_cnt !== 8'd2) begin fails++; $display("FAIL ill_fmt7 got %h err=%0b cnt=%0d want 0/1/2", imm_out, imm_err, err_cnt); end
    pop_one();
    instr = 32'hFFFF_FFFF; fmt = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (i == 251) begin
        tests++; if (err_cnt !== 8'd254) begin fails++; $display("FAIL ill_cnt254 got %0d want 254", err_cnt); end
      end
      if (i == 252) begin
        tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL ill_cnt255 got %0d want 255", err_cnt); end
      end
    end
    tests++; if (err_cnt !== 8'd255 || imm_err !== 1'b1 || imm_out !== 64'd0 || occupancy !== 2'd1) begin fails++; $display("FAIL ill_sat got cnt=%0d err=%0b imm=%h occ=%0d want 255/1/0/1", err_cnt, imm_err, imm_out, occupancy); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL ill_drain got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_async_reset();
    push_one(32'd5 << 10, 3'd0);
    push_one(32'd6 << 10, 3'd0);
    tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL ar_pre got occ=%0d want 2", occupancy); end
    in_valid = 1'b1; instr = 32'd7 << 10;
    #3 reset = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL ar_now got v=%0b occ=%0d rdy=%0b want 0/0/1", out_valid, occupancy, in_ready); end
    tests++; if (err_cnt !== 8'd0 || imm_out !== 64'd0) begin fails++; $display("FAIL ar_clear got cnt=%0d imm=%h want 0/0", err_cnt, imm_out); end
    @(posedge clk); #1;
    tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL ar_no_push got occ=%0d want 0", occupancy); end
    reset = 1'b0; in_valid = 1'b0;
    push_one(32'd9 << 10, 3'd0);
    tests++; if (imm_out !== 64'd9 || occupancy !== 2'd1) begin fails++; $display("FAIL ar_after got %h occ=%0d want 9/1", imm_out, occupancy); end
    pop_one();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; fmt = '0;
    #12;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_formats();
    test_backpressure();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
